result_scan: RTL

- Post-run readback stage that sits directly downstream of the processor top.
- Waits for the processor's done flag to rise, then reads a window of data memory through its own synchronous read port.
- Streams each byte out as an {address, data} pair over a valid/ready handshake and keeps a running 8-bit checksum.
- Used by the bench and the board harness to extract program results (e.g. mem[5], mem[6]) without poking memory hierarchically.

---
 rtl/result_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/result_scan.sv
// result_scan
//   Post-run readback stage. After the processor's done flag rises, reads a
//   window of data memory through a synchronous read port and streams every
//   byte out as an {address, data} pair on a valid/ready handshake, keeping a
//   running 8-bit checksum of the bytes accepted during the scan.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   done        processor done flag (level); its rising edge starts a scan
//   start_addr  first address of the window, sampled at trigger
//   length      byte count of the window, sampled at trigger (0 = empty)
//   mem_rd      read strobe to the data-memory read port
//   mem_addr    read address
//   mem_data    read data, valid one cycle after mem_rd
//   out_valid   output pair valid
//   out_ready   consumer accepts the pair
//   out_addr    address of the current output byte
//   out_data    byte read from memory
//   checksum    sum mod 256 of the bytes accepted this scan
//   busy        scan in progress
//   scan_done   window fully transferred, held until done falls
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a rising edge on done
// READ  | read strobe issued for the current address
// CAPT  | memory data returned, captured into the output registers
// HOLD  | pair presented, waiting for out_ready
// FIN   | window finished, waiting for done to fall

module result_scan #(
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 8,
   parameter logic [7:0]  CHK_INIT = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              done,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        length,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [7:0]        checksum,
   output logic              busy,
   output logic              scan_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      CAPT = 3'd2,
      HOLD = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t            state_q;
   logic              done_q;
   logic [ADDR_W-1:0] cur_q;
   logic [7:0]        rem_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              out_valid_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic [7:0]        checksum_q;
   logic              scan_done_q;

   logic [ADDR_W-1:0] cur_inc_d;
   logic [7:0]        checksum_d;

   assign cur_inc_d  = cur_q + ADDR_W'(1);
   assign checksum_d = checksum_q + 8'(out_data_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         // Starting high means a done that is already asserted when reset
         // releases must fall and rise again before it can start a scan.
         done_q      <= 1'b1;
         cur_q       <= '0;
         rem_q       <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         checksum_q  <= CHK_INIT;
         scan_done_q <= 1'b0;
      end else begin
         done_q   <= done;
         mem_rd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (done && !done_q) begin
                  cur_q      <= start_addr;
                  rem_q      <= length;
                  checksum_q <= CHK_INIT;
                  if (length == 8'd0) begin
                     state_q     <= FIN;
                     scan_done_q <= 1'b1;
                  end else begin
                     state_q    <= READ;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= start_addr;
                  end
               end
            end
            READ: begin
               state_q <= CAPT;
            end
            CAPT: begin
               out_data_q  <= mem_data;
               out_addr_q  <= cur_q;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  checksum_q  <= checksum_d;
                  cur_q       <= cur_inc_d;
                  rem_q       <= rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
                     state_q     <= FIN;
                     scan_done_q <= 1'b1;
                  end else begin
                     // Issue the next read directly from the handshake edge so
                     // a ready-high consumer sees one byte every three cycles.
                     state_q    <= READ;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= cur_inc_d;
                  end
               end
            end
            FIN: begin
               if (!done) begin
                  state_q     <= IDLE;
                  scan_done_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_rd    = mem_rd_q;
   assign mem_addr  = mem_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign checksum  = checksum_q;
   assign scan_done = scan_done_q;
   assign busy      = (state_q == READ) || (state_q == CAPT) || (state_q == HOLD);

endmodule
